// File: rtl/mem_pkg.sv
// Shared constants for the main-memory responder: default parameters,
// FSM state encoding and a small width helper.
package mem_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_BLOCK_WIDTH    = 32;
    localparam int DEF_MEM_DEPTH      = 1024;
    localparam int DEF_ACCESS_LATENCY = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised backing store: one synchronous write port used for preload,
// one combinational read port used by the fetch sequencer.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int IDX_W      = clog2_min1(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [IDX_W-1:0]      write_idx,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [IDX_W-1:0]      read_idx,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] words [MEM_DEPTH];

    // NOTE: the array has no reset on purpose; preloaded contents must survive
    // rst, and a reset would also stop it mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (write_en) begin
            words[write_idx] <= write_data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle preload returns old data.
    assign read_data = words[read_idx];

endmodule

// File: rtl/main_memory_responder.sv
// Block-read responder: accepts a byte address, waits ACCESS_LATENCY cycles,
// gathers BEATS consecutive words into one block and pulses read_done.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int BLOCK_WIDTH    = DEF_BLOCK_WIDTH,
    parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
    parameter int ACCESS_LATENCY = DEF_ACCESS_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_enable,
    input  logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [BLOCK_WIDTH-1:0]   memory_block,
    output logic                     read_done,
    input  logic                     load_en,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data
);

    localparam int BEATS       = BLOCK_WIDTH / DATA_WIDTH;
    localparam int WORD_BYTES  = DATA_WIDTH / 8;
    localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;
    localparam int IDX_W       = clog2_min1(MEM_DEPTH);
    localparam int CNT_W       = clog2_min1(ACCESS_LATENCY + 1);
    localparam int BEAT_W      = clog2_min1(BEATS);

    logic [1:0]               state;
    logic [CNT_W-1:0]         wait_cnt;
    logic [BEAT_W-1:0]        beat;
    logic [IDX_W-1:0]         base_idx;
    logic [BLOCK_WIDTH-1:0]   block_q;

    logic                     accept;
    logic                     last_beat;
    logic [ADDRESS_WIDTH-1:0] req_word;
    logic [ADDRESS_WIDTH-1:0] load_word;
    logic [IDX_W-1:0]         fetch_idx;
    logic [DATA_WIDTH-1:0]    fetch_word;

    // Aligning down to the block and converting to a word index in one step;
    // truncation to IDX_W bits gives the modulo-MEM_DEPTH wrap.
    assign req_word  = (memory_address / ADDRESS_WIDTH'(BLOCK_BYTES)) * ADDRESS_WIDTH'(BEATS);
    assign load_word = load_addr / ADDRESS_WIDTH'(WORD_BYTES);

    assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && mem_enable;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign fetch_idx = base_idx + IDX_W'(beat);

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clk        (clk),
        .write_en   (load_en),
        .write_idx  (IDX_W'(load_word)),
        .write_data (load_data),
        .read_idx   (fetch_idx),
        .read_data  (fetch_word)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            beat     <= '0;
            base_idx <= '0;
            block_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        base_idx <= IDX_W'(req_word);
                        beat     <= '0;
                        if (ACCESS_LATENCY == 0) begin
                            state <= ST_FETCH;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= CNT_W'(ACCESS_LATENCY);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt <= CNT_W'(1)) begin
                        wait_cnt <= '0;
                        state    <= ST_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                ST_FETCH: begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat == BEAT_W'(k)) begin
                            block_q[k*DATA_WIDTH +: DATA_WIDTH] <= fetch_word;
                        end
                    end
                    if (last_beat) begin
                        beat  <= '0;
                        state <= ST_DONE;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign memory_block = block_q;
    assign read_done    = (state == ST_DONE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: three configurations share one
// clock; expected blocks and latencies go through a scoreboard queue.
module tb_main_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_enable     [3];
    logic [31:0] memory_address [3];
    logic        load_en        [3];
    logic [31:0] load_addr      [3];
    logic [31:0] load_data      [3];
    logic        read_done      [3];
    logic [31:0]  block_a;
    logic [127:0] block_b;
    logic [31:0]  block_c;

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    main_memory_responder dut_a (
        .clk(clk), .rst(rst),
        .mem_enable(mem_enable[0]), .memory_address(memory_address[0]),
        .memory_block(block_a), .read_done(read_done[0]),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
    );

    main_memory_responder #(.BLOCK_WIDTH(128), .ACCESS_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst),
        .mem_enable(mem_enable[1]), .memory_address(memory_address[1]),
        .memory_block(block_b), .read_done(read_done[1]),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
    );

    main_memory_responder #(.ACCESS_LATENCY(0)) dut_c (
        .clk(clk), .rst(rst),
        .mem_enable(mem_enable[2]), .memory_address(memory_address[2]),
        .memory_block(block_c), .read_done(read_done[2]),
        .load_en(load_en[2]), .load_addr(load_addr[2]), .load_data(load_data[2])
    );

    function automatic logic [127:0] blk(input int d);
        case (d)
            0:       return {96'b0, block_a};
            1:       return block_b;
            default: return {96'b0, block_c};
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int d, input logic [31:0] addr, input logic [31:0] data);
        load_en[d]   = 1'b1;
        load_addr[d] = addr;
        load_data[d] = data;
        @(negedge clk);
        load_en[d] = 1'b0;
    endtask

    // lat counts negedges from now until the DONE cycle is visible.
    task automatic request(input int d, input logic [31:0] addr, input logic [127:0] data, input int lat);
        exp_t e;
        mem_enable[d]     = 1'b1;
        memory_address[d] = addr;
        e.data = data;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic expect_done(input int d, input string tag);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!read_done[d] && n < 40);
        check({tag, "_lat"}, 128'(n), 128'(e.lat));
        check({tag, "_data"}, blk(d), e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_enable[i]     = 1'b0;
            memory_address[i] = '0;
            load_en[i]        = 1'b0;
            load_addr[i]      = '0;
            load_data[i]      = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_done_%0d", i), 128'(read_done[i]), 128'(0));
            check($sformatf("rst_block_%0d", i), blk(i), 128'(0));
        end
        rst = 1'b0;

        preload(0, 32'h40, 32'hDEADBEEF);
        preload(0, 32'h80, 32'hCAFEF00D);
        preload(1, 32'h100, 32'd1);
        preload(1, 32'h104, 32'd2);
        preload(1, 32'h108, 32'd3);
        preload(1, 32'h10C, 32'd4);
        preload(2, 32'h40, 32'hDEADBEEF);

        // Basic read with default latency
        request(0, 32'h40, 128'hDEADBEEF, 6);
        expect_done(0, "a_basic");
        mem_enable[0] = 1'b0;
        @(negedge clk);
        check("a_pulse_width", 128'(read_done[0]), 128'(0));
        check("a_hold", blk(0), 128'hDEADBEEF);

        // Low address bits ignored, then back-to-back from the DONE cycle
        request(0, 32'h43, 128'hDEADBEEF, 6);
        expect_done(0, "a_lowbits");
        request(0, 32'h80, 128'hCAFEF00D, 6);
        expect_done(0, "a_b2b");
        mem_enable[0] = 1'b0;
        @(negedge clk);
        check("a_b2b_end", 128'(read_done[0]), 128'(0));

        // Request dropped and address changed during WAIT
        request(0, 32'h40, 128'hDEADBEEF, 5);
        @(negedge clk);
        mem_enable[0]     = 1'b0;
        memory_address[0] = 32'h80;
        expect_done(0, "a_drop");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("a_idle_%0d", i), 128'(read_done[0]), 128'(0));
        end
        check("a_drop_hold", blk(0), 128'hDEADBEEF);

        // Reset during FETCH
        mem_enable[0]     = 1'b1;
        memory_address[0] = 32'h80;
        repeat (5) @(negedge clk);
        rst           = 1'b1;
        mem_enable[0] = 1'b0;
        @(negedge clk);
        check("a_rst_done", 128'(read_done[0]), 128'(0));
        check("a_rst_block", blk(0), 128'(0));
        rst = 1'b0;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (read_done[0]) saw = 1;
        end
        check("a_rst_no_done", 128'(saw), 128'(0));
        request(0, 32'h40, 128'hDEADBEEF, 6);
        expect_done(0, "a_after_rst");
        mem_enable[0] = 1'b0;
        @(negedge clk);

        // Preload of the word being fetched returns old contents
        request(0, 32'h40, 128'hDEADBEEF, 1);
        repeat (5) @(negedge clk);
        mem_enable[0] = 1'b0;
        load_en[0]    = 1'b1;
        load_addr[0]  = 32'h40;
        load_data[0]  = 32'h12345678;
        expect_done(0, "a_collide");
        load_en[0] = 1'b0;
        @(negedge clk);
        request(0, 32'h40, 128'h12345678, 6);
        expect_done(0, "a_new_word");
        mem_enable[0] = 1'b0;

        // Multi-beat block
        request(1, 32'h104, {32'd4, 32'd3, 32'd2, 32'd1}, 7);
        expect_done(1, "b_block");
        mem_enable[1] = 1'b0;
        @(negedge clk);

        // Zero latency with address wrap
        request(2, 32'h1040, 128'hDEADBEEF, 2);
        expect_done(2, "c_wrap");
        mem_enable[2] = 1'b0;
        @(negedge clk);

        // Reset wins over acceptance in the same cycle
        rst               = 1'b1;
        mem_enable[2]     = 1'b1;
        memory_address[2] = 32'h40;
        @(negedge clk);
        rst           = 1'b0;
        mem_enable[2] = 1'b0;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (read_done[2]) saw = 1;
        end
        check("c_rst_priority", 128'(saw), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
